// File: rtl/chdr_pkt_rr_arbiter.sv
// Packet-atomic round-robin arbiter sharing one 64-bit CHDR AXI-Stream output.
// A grant is held from header to tlast; each packet's word count is checked against its length.
module chdr_pkt_rr_arbiter #(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned DWIDTH    = 64
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_PORTS-1:0]         port_en,
  input  logic [DWIDTH*NUM_PORTS-1:0]  i_tdata,
  input  logic [NUM_PORTS-1:0]         i_tlast,
  input  logic [NUM_PORTS-1:0]         i_tvalid,
  output logic [NUM_PORTS-1:0]         i_tready,
  output logic [DWIDTH-1:0]            o_tdata,
  output logic                         o_tlast,
  output logic                         o_tvalid,
  input  logic                         o_tready,
  output logic [NUM_PORTS-1:0]         grant,
  output logic                         busy,
  output logic                         err_len,
  output logic [$clog2(NUM_PORTS)-1:0] err_port
);

  localparam int unsigned IdxW = $clog2(NUM_PORTS);

  typedef enum logic {StArb, StPkt} state_e;

  state_e               state_q, state_d;
  logic [NUM_PORTS-1:0] grant_q, grant_d;
  // Index of the most recent grant; also selects the datapath while in StPkt.
  logic [IdxW-1:0]      last_grant_q, last_grant_d;
  logic [12:0]          word_cnt_q, word_cnt_d;
  logic [13:0]          exp_words_q, exp_words_d;
  logic                 err_len_q, err_len_d;
  logic [IdxW-1:0]      err_port_q, err_port_d;

  logic [NUM_PORTS-1:0] req;
  logic                 req_any;
  logic [IdxW-1:0]      sel_idx;

  logic [DWIDTH-1:0]    g_data;
  logic                 g_last;
  logic                 g_valid;
  logic                 hs;
  logic [16:0]          len_rnd;
  logic [13:0]          exp_first;
  logic [13:0]          exp_now;
  logic [13:0]          cnt_p1;

  // Round-robin search starting just above the previous grant.
  always_comb begin
    req     = i_tvalid & port_en;
    req_any = |req;
    sel_idx = '0;
    for (int i = NUM_PORTS; i >= 1; i--) begin
      int unsigned idx;
      idx = (int'(last_grant_q) + i) % NUM_PORTS;
      if (req[idx]) sel_idx = IdxW'(idx);
    end
  end

  assign g_data  = i_tdata[DWIDTH*last_grant_q +: DWIDTH];
  assign g_last  = i_tlast[last_grant_q];
  assign g_valid = i_tvalid[last_grant_q];
  assign hs      = (state_q == StPkt) && g_valid && o_tready;

  // Expected words = ceil(length / 8), never less than one.
  assign len_rnd   = {1'b0, g_data[47:32]} + 17'd7;
  assign exp_first = (len_rnd[16:3] == 14'd0) ? 14'd1 : len_rnd[16:3];
  assign exp_now   = (word_cnt_q == 13'd0) ? exp_first : exp_words_q;
  assign cnt_p1    = {1'b0, word_cnt_q} + 14'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StArb;
      grant_q      <= '0;
      last_grant_q <= IdxW'(NUM_PORTS - 1);
      word_cnt_q   <= '0;
      exp_words_q  <= 14'd1;
      err_len_q    <= 1'b0;
      err_port_q   <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      word_cnt_q   <= word_cnt_d;
      exp_words_q  <= exp_words_d;
      err_len_q    <= err_len_d;
      err_port_q   <= err_port_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    word_cnt_d   = word_cnt_q;
    exp_words_d  = exp_words_q;
    err_len_d    = 1'b0;
    err_port_d   = err_port_q;
    unique case (state_q)
      StArb: begin
        if (req_any) begin
          state_d      = StPkt;
          grant_d      = {{(NUM_PORTS-1){1'b0}}, 1'b1} << sel_idx;
          last_grant_d = sel_idx;
          word_cnt_d   = '0;
        end
      end
      StPkt: begin
        if (hs) begin
          if (word_cnt_q != 13'h1fff) word_cnt_d = word_cnt_q + 13'd1;
          if (word_cnt_q == 13'd0) exp_words_d = exp_first;
          if (g_last) begin
            state_d = StArb;
            grant_d = '0;
            if (cnt_p1 != exp_now) begin
              err_len_d  = 1'b1;
              err_port_d = last_grant_q;
            end
          end
        end
      end
      default: state_d = StArb;
    endcase
  end

  always_comb begin
    o_tdata  = '0;
    o_tlast  = 1'b0;
    o_tvalid = 1'b0;
    i_tready = '0;
    if (state_q == StPkt) begin
      o_tdata                = g_data;
      o_tlast                = g_last;
      o_tvalid               = g_valid;
      i_tready[last_grant_q] = o_tready;
    end
  end

  assign grant    = grant_q;
  assign busy     = (state_q == StPkt);
  assign err_len  = err_len_q;
  assign err_port = err_port_q;

endmodule
